// File: rtl/cpu_control_sequencer_if.sv
// Datapath-facing bundle of the Mini-SRC control sequencer.
// master drives the control word; slave is the datapath side.
interface cpu_control_sequencer_if;
  logic        stop;
  logic [31:0] IR;
  logic        CON;
  logic        run;
  logic [31:0] ctrl;

  modport master (
    input  stop, IR, CON,
    output run, ctrl
  );

  modport slave (
    output stop, IR, CON,
    input  run, ctrl
  );
endinterface

// File: rtl/cpu_control_sequencer.sv
// Hardwired Mini-SRC control sequencer: fetch, decode, execute.
// Control word is a pure decode of state plus IR opcode and CON.
module cpu_control_sequencer #(
  parameter int MEM_WAIT = 0
) (
  input logic                     Clock,
  input logic                     clear,
  cpu_control_sequencer_if.master bus
);

  localparam logic [31:0] PCOUT  = 32'h0000_0001;
  localparam logic [31:0] PCIN   = 32'h0000_0002;
  localparam logic [31:0] INCPC  = 32'h0000_0004;
  localparam logic [31:0] MARIN  = 32'h0000_0008;
  localparam logic [31:0] MDRIN  = 32'h0000_0010;
  localparam logic [31:0] MDROUT = 32'h0000_0020;
  localparam logic [31:0] READ   = 32'h0000_0040;
  localparam logic [31:0] WRITE  = 32'h0000_0080;
  localparam logic [31:0] IRIN   = 32'h0000_0100;
  localparam logic [31:0] YIN    = 32'h0000_0200;
  localparam logic [31:0] ZLO    = 32'h0000_0400;
  localparam logic [31:0] ZHI    = 32'h0000_0800;
  localparam logic [31:0] ZLOUT  = 32'h0000_1000;
  localparam logic [31:0] ZHOUT  = 32'h0000_2000;
  localparam logic [31:0] HIIN   = 32'h0000_4000;
  localparam logic [31:0] LOIN   = 32'h0000_8000;
  localparam logic [31:0] HIOUT  = 32'h0001_0000;
  localparam logic [31:0] LOOUT  = 32'h0002_0000;
  localparam logic [31:0] GRA    = 32'h0004_0000;
  localparam logic [31:0] GRB    = 32'h0008_0000;
  localparam logic [31:0] GRC    = 32'h0010_0000;
  localparam logic [31:0] RIN    = 32'h0020_0000;
  localparam logic [31:0] ROUT   = 32'h0040_0000;
  localparam logic [31:0] BAOUT  = 32'h0080_0000;
  localparam logic [31:0] COUT   = 32'h0100_0000;
  localparam logic [31:0] CONIN  = 32'h0200_0000;
  localparam logic [31:0] INPOUT = 32'h0400_0000;
  localparam logic [31:0] OUTEN  = 32'h0800_0000;
  localparam logic [31:0] LINK   = 32'h2000_0000;

  // FW lasts MEM_WAIT cycles; the ld E3 read spans MEM_WAIT cycles, min one
  localparam bit         HAS_WAIT = MEM_WAIT != 0;
  localparam logic [1:0] RELOAD   = 2'(MEM_WAIT == 0 ? 0 : MEM_WAIT - 1);

  typedef enum logic [3:0] {
    S_RST, S_F0, S_F1, S_FW, S_F2, S_F3,
    S_E0, S_E1, S_E2, S_E3, S_E4, S_E5,
    S_STOP, S_HALT
  } state_t;

  state_t      state, state_n, s_end;
  logic [1:0]  cnt, cnt_n;
  logic [4:0]  op;
  logic [2:0]  n_e, idx;
  logic        last;
  logic [31:0] cw;
  logic        c_alu, c_imm, c_neg, c_mul, c_ld, c_ldi, c_st, c_brx;
  logic        c_jr, c_jal, c_in, c_out, c_mfhi, c_mflo, c_halt, c_nop;
  logic        unused_ir;

  assign op        = bus.IR[31:27];
  assign unused_ir = ^bus.IR[26:0];

  assign c_ld   = op == 5'd0;
  assign c_ldi  = op == 5'd1;
  assign c_st   = op == 5'd2;
  assign c_alu  = op >= 5'd3 && op <= 5'd11;
  assign c_imm  = op >= 5'd12 && op <= 5'd14;
  assign c_mul  = op == 5'd15 || op == 5'd16;
  assign c_neg  = op == 5'd17 || op == 5'd18;
  assign c_brx  = op == 5'd19;
  assign c_jr   = op == 5'd20;
  assign c_jal  = op == 5'd21;
  assign c_in   = op == 5'd22;
  assign c_out  = op == 5'd23;
  assign c_mfhi = op == 5'd24;
  assign c_mflo = op == 5'd25;
  assign c_halt = op == 5'd27;
  assign c_nop  = op == 5'd26 || op >= 5'd28;

  // Execute length per class and position of the current E step
  always_comb begin
    n_e = 3'd0;
    unique case (1'b1)
      c_jr, c_in, c_out, c_mfhi, c_mflo: n_e = 3'd1;
      c_neg, c_jal:                      n_e = 3'd2;
      c_alu, c_imm, c_ldi:               n_e = 3'd3;
      c_mul, c_brx:                      n_e = 3'd4;
      c_st:                              n_e = 3'd5;
      c_ld:                              n_e = 3'd6;
      c_halt, c_nop:                     n_e = 3'd0;
    endcase
    unique case (state)
      S_E0:    idx = 3'd0;
      S_E1:    idx = 3'd1;
      S_E2:    idx = 3'd2;
      S_E3:    idx = 3'd3;
      S_E4:    idx = 3'd4;
      S_E5:    idx = 3'd5;
      default: idx = 3'd7;
    endcase
    last = n_e != 3'd0 && idx == n_e - 3'd1;
  end

  // State and wait-counter registers
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state <= S_RST;
      cnt   <= 2'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state; stop only acts at the fetch boundary
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    s_end   = bus.stop ? S_STOP : S_F0;
    unique case (state)
      S_RST:  state_n = s_end;
      S_STOP: if (!bus.stop) state_n = S_F0;
      S_HALT: state_n = S_HALT;
      S_F0:   state_n = S_F1;
      S_F1: begin
        if (HAS_WAIT) begin
          state_n = S_FW;
          cnt_n   = RELOAD;
        end else begin
          state_n = S_F2;
        end
      end
      S_FW: begin
        if (cnt == 2'd0) state_n = S_F2;
        else cnt_n = cnt - 2'd1;
      end
      S_F2: state_n = S_F3;
      S_F3: begin
        if (c_halt)     state_n = S_HALT;
        else if (c_nop) state_n = s_end;
        else            state_n = S_E0;
      end
      S_E0: state_n = last ? s_end : S_E1;
      S_E1: state_n = last ? s_end : S_E2;
      S_E2: begin
        state_n = last ? s_end : S_E3;
        if (!last) cnt_n = RELOAD;
      end
      S_E3: begin
        if (c_ld && cnt != 2'd0) cnt_n = cnt - 2'd1;
        else state_n = last ? s_end : S_E4;
      end
      S_E4: state_n = last ? s_end : S_E5;
      S_E5: state_n = s_end;
      default: state_n = S_RST;
    endcase
  end

  // Control word decode
  always_comb begin
    cw = '0;
    unique case (state)
      S_F0: cw = PCOUT | MARIN | INCPC | ZLO;
      S_F1: cw = ZLOUT | PCIN | READ;
      S_FW: cw = READ;
      S_F2: cw = READ | MDRIN;
      S_F3: cw = MDROUT | IRIN;
      S_E0, S_E1, S_E2, S_E3, S_E4, S_E5: begin
        unique case (1'b1)
          c_alu, c_imm: begin
            if (idx == 3'd0)      cw = GRB | ROUT | YIN;
            else if (idx == 3'd1) cw = c_alu ? (GRC | ROUT | ZLO) : (COUT | ZLO);
            else                  cw = ZLOUT | GRA | RIN;
          end
          c_ld, c_ldi, c_st: begin
            unique case (idx)
              3'd0: cw = GRB | BAOUT | YIN;
              3'd1: cw = COUT | ZLO;
              3'd2: cw = c_ldi ? (ZLOUT | GRA | RIN) : (ZLOUT | MARIN);
              3'd3: cw = c_st ? (GRA | ROUT | MDRIN) : READ;
              3'd4: cw = c_st ? WRITE : (READ | MDRIN);
              default: cw = MDROUT | GRA | RIN;
            endcase
          end
          c_mul: begin
            unique case (idx)
              3'd0:    cw = GRA | ROUT | YIN;
              3'd1:    cw = GRB | ROUT | ZLO | ZHI;
              3'd2:    cw = ZLOUT | LOIN;
              default: cw = ZHOUT | HIIN;
            endcase
          end
          c_neg: cw = idx == 3'd0 ? (GRB | ROUT | ZLO) : (ZLOUT | GRA | RIN);
          c_brx: begin
            unique case (idx)
              3'd0:    cw = GRA | ROUT | CONIN;
              3'd1:    cw = PCOUT | YIN;
              3'd2:    cw = COUT | ZLO;
              default: cw = ZLOUT | (bus.CON ? PCIN : 32'h0);
            endcase
          end
          c_jr:   cw = GRA | ROUT | PCIN;
          c_jal:  cw = idx == 3'd0 ? (PCOUT | LINK) : (GRA | ROUT | PCIN);
          c_in:   cw = INPOUT | GRA | RIN;
          c_out:  cw = GRA | ROUT | OUTEN;
          c_mfhi: cw = HIOUT | GRA | RIN;
          c_mflo: cw = LOOUT | GRA | RIN;
          c_halt, c_nop: cw = '0;
        endcase
      end
      default: cw = '0;
    endcase
  end

  assign bus.ctrl = cw;
  assign bus.run  = state != S_RST && state != S_STOP && state != S_HALT;

endmodule
